// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one sdram_controller user port between requester 0
// (CPU Wishbone bridge) and requester 1 (DMA/prefetch engine).
// Latency: request seen in IDLE at T drives sd_in_valid_o at T+1. out_valid at K
// returns a one-cycle mX_ack_o at K+1. The earliest next access starts at K+3.
// Backpressure: a request is held until its ack. Losing requesters simply wait.
// Optional macro SDRAM_ARB_AGING_EN: lets a starved requester 1 win after
// STARVE_LIMIT cycles. Without it, requester 0 has strict priority.
// Ports: clk/rst (sync, active-high); m0_*/m1_* requester ports (req, we, addr,
//   wdata in; rdata, ack out); sd_* controller user port (in_valid, rw, addr,
//   wdata out; rdata, out_valid in). All outputs are registered.
module sdram_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic              m0_ack_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              m1_ack_o,
  output logic              sd_in_valid_o,
  output logic              sd_rw_o,
  output logic [ADDR_W-1:0] sd_addr_o,
  output logic [DATA_W-1:0] sd_wdata_o,
  input  logic [DATA_W-1:0] sd_rdata_i,
  input  logic              sd_out_valid_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ACK = 2'd2} state_t;

  state_t              state_q;
  logic                gnt_q;        // 0: requester 0 owns the access, 1: requester 1
  logic                gnt_d;        // winner if arbitration happens this cycle
  logic                any_req;
  logic                aged;         // requester 1 has waited long enough to be forced in
  logic                in_valid_q;
  logic                rw_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   m0_rdata_q;
  logic [DATA_W-1:0]   m1_rdata_q;
  logic                m0_ack_q;
  logic                m1_ack_q;

  always_comb begin
    any_req = m0_req_i | m1_req_i;
    gnt_d   = !m0_req_i || (m1_req_i && aged);
  end

`ifdef SDRAM_ARB_AGING_EN
  logic [7:0] wait1_q;
  logic [7:0] wait1_d;
  logic       m1_served;

  always_comb begin
    aged      = ({24'd0, wait1_q} >= 32'(STARVE_LIMIT));
    // Requester 1 counts as granted for its whole BUSY/ACK window.
    m1_served = (state_q != IDLE) && gnt_q;
    wait1_d   = wait1_q;
    if (state_q == IDLE && any_req && gnt_d) begin
      wait1_d = 8'd0;
    end else if (m1_req_i && !m1_served && wait1_q != 8'hFF) begin
      wait1_d = wait1_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wait1_q <= 8'd0;
    else     wait1_q <= wait1_d;
  end
`else
  assign aged = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      in_valid_q <= 1'b0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_q      <= gnt_d;
            in_valid_q <= 1'b1;
            rw_q       <= gnt_d ? m1_we_i    : m0_we_i;
            addr_q     <= gnt_d ? m1_addr_i  : m0_addr_i;
            wdata_q    <= gnt_d ? m1_wdata_i : m0_wdata_i;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          // Completes even if the owner dropped req mid-access.
          if (sd_out_valid_i) begin
            in_valid_q <= 1'b0;
            state_q    <= ACK;
            if (gnt_q) begin
              m1_ack_q <= 1'b1;
              if (!rw_q) m1_rdata_q <= sd_rdata_i;
            end else begin
              m0_ack_q <= 1'b1;
              if (!rw_q) m0_rdata_q <= sd_rdata_i;
            end
          end
        end
        ACK: begin
          // One dead cycle lets the requester see ack before the next arbitration.
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sd_in_valid_o = in_valid_q;
  assign sd_rw_o       = rw_q;
  assign sd_addr_o     = addr_q;
  assign sd_wdata_o    = wdata_q;
  assign m0_rdata_o    = m0_rdata_q;
  assign m1_rdata_o    = m1_rdata_q;
  assign m0_ack_o      = m0_ack_q;
  assign m1_ack_o      = m1_ack_q;

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-requester arbiter that shares the single `sdram_controller` user port between the CPU-side Wishbone bridge (requester 0) and the DMA/prefetch engine (requester 1). It registers the winning request, drives the controller's `in_valid`/`rw`/`user_addr`/`data_in` until the controller returns `out_valid`, and routes the result back as a one-cycle acknowledge with registered read data. It deasserts `in_valid` the cycle after `out_valid`, so a held request never triggers a second controller access.

## Interface
- `ADDR_W`, 32, address width on all ports
- `DATA_W`, 32, data width on all ports
- `STARVE_LIMIT`, 16, cycles requester 1 may wait before it is forced to win (only with `SDRAM_ARB_AGING_EN`)

- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `m0_req`  in  1  requester 0 request; held until `m0_ack`
- `m0_we`  in  1  1 = write, 0 = read
- `m0_addr`  in  ADDR_W  byte address
- `m0_wdata`  in  DATA_W  write data
- `m0_rdata`  out  DATA_W  read data, valid with `m0_ack`
- `m0_ack`  out  1  one-cycle completion pulse
- `m1_req`, `m1_we`, `m1_addr`, `m1_wdata`, `m1_rdata`, `m1_ack`: same as the `m0_*` ports, for requester 1
- `sd_in_valid`  out  1  to controller `in_valid`
- `sd_rw`  out  1  to controller `rw`
- `sd_addr`  out  ADDR_W  to controller `user_addr`
- `sd_wdata`  out  DATA_W  to controller `data_in`
- `sd_rdata`  in  DATA_W  from controller `data_out`
- `sd_out_valid`  in  1  from controller `out_valid`

## Operation
- FSM states: IDLE, BUSY, ACK. Reset state is IDLE.
- **IDLE:**
  - If any request is high, select a winner and latch its we/addr/wdata into `sd_rw`/`sd_addr`/`sd_wdata`.
  - Set `sd_in_valid`=1, record the grant index, go to BUSY.
  - With no request, stay in IDLE with all outputs unchanged.
- **Priority:** requester 0 beats requester 1 when both are high in the same IDLE cycle.
- **BUSY:**
  - Hold all `sd_*` outputs stable.
  - On `sd_out_valid`=1: clear `sd_in_valid`, set `mX_ack`=1 for the granted X, capture `sd_rdata` into `mX_rdata` (reads only; writes leave `mX_rdata` unchanged), go to ACK.
- **ACK:**
  - Clear `mX_ack`, go to IDLE.
  - Requesters sample ack registered and drop or renew `req` by the IDLE cycle.
- **Non-granted requester:** its `rdata`/`ack` stay untouched.
- **Req dropped while in BUSY:** this is a protocol violation. The transaction completes and ack is still issued.
- **Address:** passes through unmodified. Remapping is done inside the controller.
- **Reset mid-BUSY:** abandons the access. All outputs go to 0 on the next edge.

## Timing
- Reset values: `sd_in_valid`=0, `sd_rw`=0, `sd_addr`=0, `sd_wdata`=0, `m0_ack`=`m1_ack`=0, `m0_rdata`=`m1_rdata`=0.
- Cycle by cycle:
  - Req seen in IDLE at cycle T → `sd_in_valid`=1 at T+1.
  - `sd_out_valid` at cycle K → `mX_ack`=1 and `sd_in_valid`=0 at K+1.
  - IDLE at K+2; the earliest next `sd_in_valid` is K+3.
- Minimum requester-visible latency: 3 cycles (controller prefetch hit: `out_valid` one cycle after `in_valid`).
- All outputs are registered. There is no combinational path from `sd_out_valid` to `mX_ack`.

## Configuration
- Macro: `SDRAM_ARB_AGING_EN`.
- **Defined:**
  - An 8-bit saturating counter `wait1` increments each cycle that `m1_req`=1 and requester 1 is not granted (IDLE/BUSY/ACK alike).
  - When `wait1` ≥ STARVE_LIMIT, requester 1 wins the next IDLE arbitration even if `m0_req`=1.
  - `wait1` clears on requester 1 grant and on reset.
- **Undefined:** the counter is absent and requester 0 always has strict priority. Requester 1 can starve.

## Test plan
- **Single read:** `m0_req` with `m0_we`=0, `m0_addr`=0x0000_0040; model returns 0xDEAD_BEEF 6 cycles after `in_valid`. Required: `sd_addr`=0x40, `m0_ack` pulses once, `m0_rdata`=0xDEAD_BEEF, `sd_in_valid` low on the ack cycle.
- **Write:** `m1_req` with `m1_we`=1, `m1_addr`=0x100, `m1_wdata`=0x1234_5678. Required: `sd_rw`=1, `sd_wdata`=0x1234_5678, `m1_ack` pulses once, `m1_rdata` stays 0.
- **Simultaneous requests** in the same IDLE cycle (aging off). Required: requester 0 served first, then requester 1. `sd_in_valid` is low for exactly 2 cycles between the two accesses.
- **Prefetch-hit back-to-back:** model asserts `out_valid` 1 cycle after `in_valid`, with requester 0 holding `req` across 4 reads. Required: exactly 4 acks and exactly 4 `sd_in_valid` rising edges.
- **Aging:** `SDRAM_ARB_AGING_EN` defined, STARVE_LIMIT=16, `m0_req` continuous, `m1_req` high. Required: requester 1 granted at the first IDLE after `wait1` reaches 16; `wait1` returns to 0.
- **Reset mid-BUSY:** assert `rst` 2 cycles after `sd_in_valid` rises. Required: all outputs 0 next cycle, FSM in IDLE, and no ack is issued.
